// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the MIPS pipeline hazard controller: FSM state encoding and register constants.
// Pure declarations; no latency and no backpressure of its own.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FLUSH_PEND = 2'd2
    } hz_state_t;

    localparam int REG_W_DEFAULT = 5;
    localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: master is the pipeline (drives hazard sources), slave is the controller.
// With HAZARD_PERF_EN defined the bundle also carries the two 32-bit performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = mips_pipe_pkg::REG_W_DEFAULT
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             mispredict;
    logic             id_jump;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_stall;
    logic             mem_timeout;
    logic [1:0]       busy_state;

`ifdef HAZARD_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mispredict, id_jump, dmem_req, dmem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_flush,
               exmem_stall, mem_timeout, busy_state,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mispredict, id_jump, dmem_req, dmem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_flush,
               exmem_stall, mem_timeout, busy_state,
               perf_stall_cnt, perf_flush_cnt
    );
`else
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mispredict, id_jump, dmem_req, dmem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_flush,
               exmem_stall, mem_timeout, busy_state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mispredict, id_jump, dmem_req, dmem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_flush,
               exmem_stall, mem_timeout, busy_state
    );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Free-running 32-bit counters of stall cycles and IF/ID flush cycles, wrapping at 2^32.
// Latency: counts visible the cycle after the event; no backpressure.
module hazard_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational off a registered FSM.
// Backpressure: dmem wait holds PC..EX/MEM; build with HAZARD_PERF_EN for the perf counters.
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_W       = REG_W_DEFAULT,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             flush_pend_q, flush_pend_d;

    logic [REG_W-1:0] rs, rt, ld_rt;
    logic             load_use;
    logic             pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c;
    logic             exmem_stall_c, mem_timeout_c;

    assign rs    = bus.id_rs;
    assign rt    = bus.id_rt;
    assign ld_rt = bus.ex_rt;

    assign load_use = bus.ex_mem_read && (ld_rt != REG_W'(REG_ZERO)) &&
                      ((ld_rt == rs) || (bus.id_uses_rt && (ld_rt == rt)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        flush_pend_d  = flush_pend_q;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_stall_c = 1'b0;
        mem_timeout_c = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.dmem_req && !bus.dmem_ready) begin
                    // Memory wait outranks a mispredict; the redirect is replayed after the wait.
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    exmem_stall_c = 1'b1;
                    flush_pend_d  = bus.mispredict;
                    wait_cnt_d    = CNT_W'(1);
                    state_d       = MEM_WAIT;
                end else if (bus.mispredict) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (bus.id_jump) begin
                    ifid_flush_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    flush_pend_d = flush_pend_q || bus.mispredict;
                    wait_cnt_d   = '0;
                    state_d      = (flush_pend_q || bus.mispredict) ? FLUSH_PEND : RUN;
                end else if (wait_cnt_q == CNT_MAX) begin
                    // Abort drops the stalled access and any redirect queued behind it.
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    exmem_stall_c = 1'b1;
                    idex_flush_c  = 1'b1;
                    mem_timeout_c = 1'b1;
                    flush_pend_d  = 1'b0;
                    wait_cnt_d    = '0;
                    state_d       = RUN;
                end else begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    exmem_stall_c = 1'b1;
                    flush_pend_d  = flush_pend_q || bus.mispredict;
                    if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            FLUSH_PEND: begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = RUN;
            end
            default: begin
                flush_pend_d = 1'b0;
                wait_cnt_d   = '0;
                state_d      = RUN;
            end
        endcase
    end

    assign bus.pc_stall    = !reset && pc_stall_c;
    assign bus.ifid_stall  = !reset && ifid_stall_c;
    assign bus.ifid_flush  = !reset && ifid_flush_c;
    assign bus.idex_flush  = !reset && idex_flush_c;
    assign bus.exmem_stall = !reset && exmem_stall_c;
    assign bus.mem_timeout = !reset && mem_timeout_c;
    assign bus.busy_state  = reset ? 2'b00 : state_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clock     (clock),
        .reset     (reset),
        .stall     (bus.pc_stall),
        .flush     (bus.ifid_flush),
        .stall_cnt (bus.perf_stall_cnt),
        .flush_cnt (bus.perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a reference model pushes expected controls per cycle,
// the observed controls are popped and compared mid-cycle.
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipe_hazard_ctrl_if #(.REG_W(5)) bus();

    pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    int m_state = 0;
    int m_cnt   = 0;
    bit m_pend  = 1'b0;
`ifdef HAZARD_PERF_EN
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, model predicts, compare 2ns later.
    task automatic step(input string tag, input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urt, input bit mr, input logic [4:0] ert,
                        input bit mp, input bit jmp, input bit req, input bit rdy);
        bit ps, is, ifl, idf, es, to, np, lu;
        int ns, nc;
        logic [7:0] e, g;
        @(negedge clock);
        reset          = rst;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_uses_rt = urt;
        bus.ex_mem_read = mr;
        bus.ex_rt      = ert;
        bus.mispredict = mp;
        bus.id_jump    = jmp;
        bus.dmem_req   = req;
        bus.dmem_ready = rdy;

        ps = 0; is = 0; ifl = 0; idf = 0; es = 0; to = 0;
        ns = m_state; nc = m_cnt; np = m_pend;
        lu = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
        if (rst) begin
            ns = 0; nc = 0; np = 0;
        end else begin
            case (m_state)
                0: begin
                    if (req && !rdy) begin
                        ps = 1; is = 1; es = 1; ns = 1; nc = 1; np = mp;
                    end else if (mp) begin
                        ifl = 1; idf = 1;
                    end else if (lu) begin
                        ps = 1; is = 1; idf = 1;
                    end else if (jmp) begin
                        ifl = 1;
                    end
                end
                1: begin
                    if (rdy) begin
                        ns = (m_pend || mp) ? 2 : 0; np = m_pend || mp; nc = 0;
                    end else if (m_cnt == 4) begin
                        ps = 1; is = 1; es = 1; idf = 1; to = 1; ns = 0; nc = 0; np = 0;
                    end else begin
                        ps = 1; is = 1; es = 1; nc = m_cnt + 1; np = m_pend || mp;
                    end
                end
                default: begin
                    ifl = 1; idf = 1; ns = 0; np = 0;
                end
            endcase
        end
        e = {ps, is, ifl, idf, es, to, (rst ? 2'd0 : 2'(m_state))};
        exp_q.push_back(e);

        #2;
        g = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_flush,
             bus.exmem_stall, bus.mem_timeout, bus.busy_state};
        check(tag, 32'(g), 32'(exp_q.pop_front()));
`ifdef HAZARD_PERF_EN
        check({tag, "_pstall"}, bus.perf_stall_cnt, rst ? 32'd0 : m_stall_cnt);
        check({tag, "_pflush"}, bus.perf_flush_cnt, rst ? 32'd0 : m_flush_cnt);
        m_stall_cnt = rst ? 32'd0 : m_stall_cnt + 32'(ps);
        m_flush_cnt = rst ? 32'd0 : m_flush_cnt + 32'(ifl);
`endif
        m_state = ns;
        m_cnt   = nc;
        m_pend  = np;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        //    tag          rst rs  rt  urt mr ert mp jmp req rdy
        step("reset0",     1, 8,  0,  0,  1, 8,  1, 0,  0,  0);
        step("reset1",     1, 0,  0,  0,  0, 0,  0, 1,  1,  0);
        step("idle",       0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        step("lu_rs",      0, 8,  0,  0,  1, 8,  0, 0,  0,  0);
        step("lu_after",   0, 8,  0,  0,  0, 8,  0, 0,  0,  0);
        step("lu_zero",    0, 0,  0,  1,  1, 0,  0, 0,  0,  0);
        step("lu_rt",      0, 3,  9,  1,  1, 9,  0, 0,  0,  0);
        step("lu_rt_nouse",0, 3,  9,  0,  1, 9,  0, 0,  0,  0);
        step("mispred",    0, 0,  0,  0,  0, 0,  1, 0,  0,  0);
        step("mp_over_lu", 0, 8,  0,  0,  1, 8,  1, 0,  0,  0);
        step("jump",       0, 0,  0,  0,  0, 0,  0, 1,  0,  0);
        step("lu_over_j",  0, 5,  0,  0,  1, 5,  0, 1,  0,  0);
        step("req_ready",  0, 0,  0,  0,  0, 0,  0, 0,  1,  1);
        // dmem wait with ready low 3 cycles
        step("mw_enter",   0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("mw_w1",      0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("mw_w2",      0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("mw_ready",   0, 0,  0,  0,  0, 0,  0, 0,  1,  1);
        step("mw_done",    0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        // mispredict while waiting is deferred to FLUSH_PEND
        step("fp_enter",   0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("fp_mp",      0, 0,  0,  0,  0, 0,  1, 0,  1,  0);
        step("fp_ready",   0, 0,  0,  0,  0, 0,  0, 0,  1,  1);
        step("fp_flush",   0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        step("fp_done",    0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        // mispredict in the same cycle that starts the wait
        step("fp2_enter",  0, 0,  0,  0,  0, 0,  1, 0,  1,  0);
        step("fp2_ready",  0, 0,  0,  0,  0, 0,  0, 0,  1,  1);
        step("fp2_flush",  0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        // timeout with MEM_TIMEOUT=4
        step("to_enter",   0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("to_w1",      0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("to_w2",      0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("to_w3",      0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("to_w4",      0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("to_after",   0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        // reset during a wait with a pending flush
        step("rst_enter",  0, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("rst_mp",     0, 0,  0,  0,  0, 0,  1, 0,  1,  0);
        step("rst_mid",    1, 0,  0,  0,  0, 0,  0, 0,  1,  0);
        step("rst_rel",    0, 0,  0,  0,  0, 0,  0, 0,  0,  0);
        step("rst_rel2",   0, 0,  0,  0,  0, 0,  0, 0,  0,  0);

        for (int i = 0; i < 200; i++) begin
            step("rand", 1'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
